// File: rtl/axi_ddr3_traffic_gen.sv
// AXI4 write/read-back traffic generator with LFSR data and a saturating error counter.
// Optional build macro TRAFFIC_GEN_LOOP_EN: continuous passes while start_i stays high.
module axi_ddr3_traffic_gen #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       ADDRS      = 27,
  parameter int unsigned       REQID      = 4,
  parameter int unsigned       BURST_LEN  = 4,
  parameter int unsigned       NUM_BURSTS = 16,
  parameter logic [ADDRS-1:0]  BASE_ADDR  = '0,
  parameter logic [31:0]       SEED       = 32'hACE1_2024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [15:0]          err_count_o,
  output logic                 axi_awvalid_o,
  input  logic                 axi_awready_i,
  output logic [ADDRS-1:0]     axi_awaddr_o,
  output logic [REQID-1:0]     axi_awid_o,
  output logic [7:0]           axi_awlen_o,
  output logic [1:0]           axi_awburst_o,
  output logic                 axi_wvalid_o,
  input  logic                 axi_wready_i,
  output logic                 axi_wlast_o,
  output logic [WIDTH/8-1:0]   axi_wstrb_o,
  output logic [WIDTH-1:0]     axi_wdata_o,
  input  logic                 axi_bvalid_i,
  output logic                 axi_bready_o,
  input  logic [1:0]           axi_bresp_i,
  input  logic [REQID-1:0]     axi_bid_i,
  output logic                 axi_arvalid_o,
  input  logic                 axi_arready_i,
  output logic [ADDRS-1:0]     axi_araddr_o,
  output logic [REQID-1:0]     axi_arid_o,
  output logic [7:0]           axi_arlen_o,
  output logic [1:0]           axi_arburst_o,
  input  logic                 axi_rvalid_i,
  output logic                 axi_rready_o,
  input  logic                 axi_rlast_i,
  input  logic [1:0]           axi_rresp_i,
  input  logic [REQID-1:0]     axi_rid_i,
  input  logic [WIDTH-1:0]     axi_rdata_i
);

  localparam int unsigned STRB_W      = WIDTH / 8;
  localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;
  localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned IDX_NEED    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned IDX_W       = (IDX_NEED > REQID) ? IDX_NEED : REQID;
  localparam int unsigned REPS        = (WIDTH + 31) / 32;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BURSTS - 1);
  localparam logic [31:0]       POLY      = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDRS-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [15:0]        err_q, err_d;
  logic               drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               wlast_q, wlast_d;
  logic               bready_q, bready_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               beat_bad, rd_end;
  logic [31:0]        pass_seed;

  // Galois form of x^32+x^22+x^2+x+1, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_data(input logic [31:0] s);
    logic [REPS*32-1:0] rep;
    rep = {REPS{s}};
    return rep[WIDTH-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

`ifdef TRAFFIC_GEN_LOOP_EN
  logic [31:0] seed_q, seed_d;
  assign pass_seed = seed_q;
`else
  assign pass_seed = SEED;
`endif

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    err_d    = err_q;
    drain_d  = drain_q;
    done_d   = done_q;
    beat_bad = 1'b0;
    rd_end   = 1'b0;
`ifdef TRAFFIC_GEN_LOOP_EN
    seed_d   = seed_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WR_ADDR;
          lfsr_d  = SEED;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          beat_d  = '0;
          err_d   = '0;
          drain_d = 1'b0;
          done_d  = 1'b0;
`ifdef TRAFFIC_GEN_LOOP_EN
          seed_d  = SEED;
`endif
        end
      end
      S_WR_ADDR: if (axi_awready_i) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (axi_wready_i) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_WR_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_WR_RESP: begin
        if (axi_bvalid_i) begin
          if ((axi_bresp_i != 2'b00) || (axi_bid_i != idx_q[REQID-1:0])) err_d = sat_inc(err_q);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            addr_d  = BASE_ADDR;
            lfsr_d  = pass_seed;
            state_d = S_RD_ADDR;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + ADDRS'(BURST_BYTES);
            state_d = S_WR_ADDR;
          end
        end
      end
      S_RD_ADDR: if (axi_arready_i) state_d = S_RD_DATA;
      S_RD_DATA: begin
        // After an early rlast, step the LFSR over the missing beats so later bursts stay aligned.
        if (drain_q) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (beat_q == LAST_BEAT) begin
            drain_d = 1'b0;
            beat_d  = '0;
            rd_end  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (axi_rvalid_i) begin
          beat_bad = (axi_rdata_i != lfsr_data(lfsr_q)) || (axi_rresp_i != 2'b00) ||
                     (axi_rid_i != idx_q[REQID-1:0]) || (axi_rlast_i != (beat_q == LAST_BEAT));
          if (beat_bad) err_d = sat_inc(err_q);
          lfsr_d = lfsr_step(lfsr_q);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            rd_end = 1'b1;
          end else begin
            beat_d  = beat_q + 1'b1;
            drain_d = axi_rlast_i;
          end
        end
        if (rd_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = addr_q + ADDRS'(BURST_BYTES);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_DONE: begin
`ifdef TRAFFIC_GEN_LOOP_EN
        if (start_i) begin
          state_d = S_WR_ADDR;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          beat_d  = '0;
          seed_d  = lfsr_q;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    awvalid_d = (state_d == S_WR_ADDR);
    wvalid_d  = (state_d == S_WR_DATA);
    wlast_d   = wvalid_d && (beat_d == LAST_BEAT);
    bready_d  = (state_d == S_WR_RESP);
    arvalid_d = (state_d == S_RD_ADDR);
    rready_d  = (state_d == S_RD_DATA) && !drain_d;
`ifdef TRAFFIC_GEN_LOOP_EN
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
`else
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    if (state_d == S_DONE) done_d = 1'b1;
`endif
    pass_d    = done_d && (err_d == 16'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      idx_q     <= '0;
      addr_q    <= BASE_ADDR;
      beat_q    <= '0;
      err_q     <= '0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`ifdef TRAFFIC_GEN_LOOP_EN
      seed_q    <= SEED;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
`ifdef TRAFFIC_GEN_LOOP_EN
      seed_q    <= seed_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign err_count_o   = err_q;
  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = idx_q[REQID-1:0];
  assign axi_awlen_o   = 8'(BURST_LEN - 1);
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wlast_o   = wlast_q;
  assign axi_wstrb_o   = {STRB_W{1'b1}};
  assign axi_wdata_o   = lfsr_data(lfsr_q);
  assign axi_bready_o  = bready_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = idx_q[REQID-1:0];
  assign axi_arlen_o   = 8'(BURST_LEN - 1);
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = rready_q;

endmodule
